// File: rtl/led_scroll_writer_if.sv
// Column-byte stream feeding the LED scroll writer.
// Producer drives in_data/in_valid; the writer answers with in_ready.
// A byte transfers on any rising edge where in_valid and in_ready are both high.
interface led_scroll_writer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/led_scroll_writer.sv
// Buffers column bytes and scrolls the 4x8 LED video memory left one column per step.
// Latency: a byte pushed into an empty FIFO reaches leds4 one cycle after the first step tick following the push.
// Backpressure: in_ready drops while the DEPTH-byte FIFO is full and is held low during reset.
module led_scroll_writer #(
  parameter int unsigned STEP_TICKS    = 1200000,
  parameter int unsigned DEPTH         = 4,
  parameter bit          FILL_ON_EMPTY = 1'b1,
  parameter logic [7:0]  FILL_BYTE     = 8'h00
) (
  input  logic                     clk12MHz,
  input  logic                     reset,
  led_scroll_writer_if.slave       stream,
  input  logic                     hold,
  output logic                     step,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               leds1,
  output logic [7:0]               leds2,
  output logic [7:0]               leds3,
  output logic [7:0]               leds4
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(STEP_TICKS);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [TW-1:0] T_LAST   = TW'(STEP_TICKS - 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [TW-1:0] timer;
  logic          tick_int;
  logic          push;
  logic          pop;
  logic          shift;
  logic [7:0]    new_col;

  // Handshake, step tick and scroll decisions; pop looks only at the count before this cycle's push
  always_comb begin
    stream.in_ready = !reset && (fifo_count != FULL_CNT);
    push            = stream.in_valid && stream.in_ready;
    tick_int        = (timer == T_LAST) && !hold;
    pop             = tick_int && (fifo_count != '0);
    shift           = tick_int && ((fifo_count != '0) || FILL_ON_EMPTY);
    new_col         = pop ? mem[rd_ptr] : FILL_BYTE;
  end

  // Step timer: free-running 0..STEP_TICKS-1, frozen while hold is high
  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      timer <= '0;
    end else if (!hold) begin
      timer <= (timer == T_LAST) ? '0 : timer + 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the pointers define what is valid
  always_ff @(posedge clk12MHz) begin
    if (push) begin
      mem[wr_ptr] <= stream.in_data;
    end
  end

  // FIFO pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      fifo_count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Video memory scroll; step marks the cycle the new columns become visible
  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      leds1 <= 8'h00;
      leds2 <= 8'h00;
      leds3 <= 8'h00;
      leds4 <= 8'h00;
      step  <= 1'b0;
    end else begin
      step <= shift;
      if (shift) begin
        leds1 <= leds2;
        leds2 <= leds3;
        leds3 <= leds4;
        leds4 <= new_col;
      end
    end
  end

endmodule
